// File: rtl/axi4_read_stream_fifo_if.sv
// ---------------------------------------------------------------------------
// axi4_read_stream_fifo_if
//   AXI4-Stream bundle from the read-data FIFO towards the AXI DMA.
//
//   tdata   DATA_W     head-of-FIFO data
//   tkeep   DATA_W/8   byte enables (all ones)
//   tvalid  1          beat available
//   tlast   1          last beat of the current packet
//   tready  1          downstream ready
//
//   master: the FIFO side. slave: the DMA side.
// ---------------------------------------------------------------------------
interface axi4_read_stream_fifo_if #(
  parameter int DATA_W = 512
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axi4_read_stream_fifo.sv
// ---------------------------------------------------------------------------
// axi4_read_stream_fifo
//   Buffers DDR read beats in a DEPTH-entry circular FIFO and drains them onto
//   an AXI4-Stream master. The DDR side has no back-pressure, so a beat that
//   arrives while the FIFO is full and not draining is dropped and counted.
//   TLAST frames packets of cfg_pkt_len beats (0 treated as 1).
//
//   clk, rst        clock, synchronous active-high reset
//   ddr_rd_data     read beat from the DDR4 adapter
//   ddr_rd_valid    beat valid (must be taken or dropped)
//   cfg_pkt_len     beats per packet, sampled at each packet start
//   err_clr         pulse clearing err and drop_cnt
//   err             sticky overflow flag
//   drop_cnt        saturating count of dropped beats
//   level           FIFO occupancy
//   almost_full     level >= AFULL_THRESH
//   latest_buf      bits [15:0] of the most recently written beat
//   m_axis          AXI4-Stream master (tdata/tkeep/tvalid/tlast/tready)
// ---------------------------------------------------------------------------
module axi4_read_stream_fifo #(
  parameter  int DATA_W       = 512,
  parameter  int DEPTH        = 8,
  parameter  int AFULL_THRESH = 6,
  parameter  int CNT_W        = 16,
  localparam int PTR_W        = $clog2(DEPTH),
  localparam int LVL_W        = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       ddr_rd_data,
  input  logic                    ddr_rd_valid,
  input  logic [15:0]             cfg_pkt_len,
  input  logic                    err_clr,
  output logic                    err,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic [LVL_W-1:0]        level,
  output logic                    almost_full,
  output logic [15:0]             latest_buf,
  axi4_read_stream_fifo_if.master m_axis
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [15:0]       beat_cnt;
  logic [15:0]       eff_len_q;
  logic [15:0]       cfg_len;
  logic [15:0]       cur_len;
  logic              full, push, pop, overflow, tlast;

  assign full     = (level == LVL_W'(DEPTH));
  assign pop      = m_axis.tvalid && m_axis.tready;
  assign push     = ddr_rd_valid && (!full || pop);
  assign overflow = ddr_rd_valid && full && !pop;

  // At a packet start the live config is used directly so that TLAST on the
  // first beat already reflects the new length; mid-packet the latched copy
  // is used so config changes only take effect at the next packet.
  assign cfg_len = (cfg_pkt_len == 16'd0) ? 16'd1 : cfg_pkt_len;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    cur_len = eff_len_q;
    if (beat_cnt == 16'd0) cur_len = cfg_len;
  end

  assign tlast = m_axis.tvalid && (beat_cnt == cur_len - 16'd1);

  assign m_axis.tdata  = mem[rd_ptr];
  assign m_axis.tkeep  = '1;
  assign m_axis.tvalid = (level != '0);
  assign m_axis.tlast  = tlast;
  assign almost_full   = (level >= LVL_W'(AFULL_THRESH));

  // NOTE: the storage array carries no reset; entries are only read when
  // level says they hold valid data, so resetting them would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ddr_rd_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      latest_buf <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        latest_buf <= ddr_rd_data[15:0];
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      // Full-with-pop pushes and pops together, so level holds at DEPTH.
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // Overflow takes priority over err_clr when both happen together.
  always_ff @(posedge clk) begin
    if (rst) begin
      err      <= 1'b0;
      drop_cnt <= '0;
    end else if (overflow) begin
      err <= 1'b1;
      if (err_clr)        drop_cnt <= CNT_W'(1);
      else if (~&drop_cnt) drop_cnt <= drop_cnt + 1'b1;
    end else if (err_clr) begin
      err      <= 1'b0;
      drop_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      eff_len_q <= 16'd1;
    end else begin
      if (beat_cnt == 16'd0) eff_len_q <= cfg_len;
      if (pop) beat_cnt <= tlast ? 16'd0 : beat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_axi4_read_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_axi4_read_stream_fifo
//   Directed bench for axi4_read_stream_fifo (DATA_W=64, DEPTH=8,
//   AFULL_THRESH=6). Inputs change 1 ns after a rising edge and outputs are
//   sampled at the same point, i.e. they show the state after that edge.
// ---------------------------------------------------------------------------
module tb_axi4_read_stream_fifo;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] ddr_rd_data;
  logic              ddr_rd_valid;
  logic [15:0]       cfg_pkt_len;
  logic              err_clr;
  logic              err;
  logic [CNT_W-1:0]  drop_cnt;
  logic [LVL_W-1:0]  level;
  logic              almost_full;
  logic [15:0]       latest_buf;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] q [$];

  axi4_read_stream_fifo_if #(.DATA_W(DATA_W)) m_axis ();

  axi4_read_stream_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_THRESH(6), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ddr_rd_data(ddr_rd_data), .ddr_rd_valid(ddr_rd_valid),
    .cfg_pkt_len(cfg_pkt_len), .err_clr(err_clr),
    .err(err), .drop_cnt(drop_cnt), .level(level),
    .almost_full(almost_full), .latest_buf(latest_buf),
    .m_axis(m_axis)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] beat(int i);
    return {16'hDA7A, 16'(i), 16'hBEEF ^ 16'(i), 16'(i * 3 + 1)};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ddr_rd_data = '0; ddr_rd_valid = 1'b0;
    cfg_pkt_len = 16'd1; err_clr = 1'b0; m_axis.tready = 1'b0;
    step(); step();

    // Reset state
    check("rst_level", 64'(level), 64'd0);
    check("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis.tlast), 64'd0);
    check("rst_afull", 64'(almost_full), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_latest", 64'(latest_buf), 64'd0);
    check("rst_tkeep", 64'(m_axis.tkeep), 64'hFF);
    rst = 1'b0;

    // 1. Back-to-back stream, one cycle latency, level never above 1
    m_axis.tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ddr_rd_valid = 1'b1; ddr_rd_data = beat(i);
      step();
      check("b2b_tdata", m_axis.tdata, beat(i));
      check("b2b_tvalid", 64'(m_axis.tvalid), 64'd1);
      check("b2b_level", 64'(level), 64'd1);
      check("b2b_tlast", 64'(m_axis.tlast), 64'd1);
    end
    ddr_rd_valid = 1'b0;
    step();
    check("b2b_drain_level", 64'(level), 64'd0);
    check("b2b_drain_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("b2b_err", 64'(err), 64'd0);

    // 2. Back-pressure: fill, almost_full from 6, ninth beat dropped
    m_axis.tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ddr_rd_valid = 1'b1; ddr_rd_data = beat(100 + i);
      q.push_back(beat(100 + i));
      step();
      check("bp_level", 64'(level), 64'(i + 1));
      check("bp_afull", 64'(almost_full), 64'((i + 1) >= 6));
      check("bp_head", m_axis.tdata, beat(100));
    end
    ddr_rd_data = beat(200);
    step();
    ddr_rd_valid = 1'b0;
    check("ovf_level", 64'(level), 64'd8);
    check("ovf_err", 64'(err), 64'd1);
    check("ovf_drop", 64'(drop_cnt), 64'd1);
    check("ovf_head", m_axis.tdata, beat(100));
    check("ovf_latest", 64'(latest_buf), 64'(beat(107) & 64'hFFFF));

    // 3. Full with simultaneous pop: level holds, no drop, order preserved
    m_axis.tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("fp_head", m_axis.tdata, q[0]);
      ddr_rd_valid = 1'b1; ddr_rd_data = beat(300 + k);
      void'(q.pop_front());
      q.push_back(beat(300 + k));
      step();
      check("fp_level", 64'(level), 64'd8);
      check("fp_drop", 64'(drop_cnt), 64'd1);
    end
    ddr_rd_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      check("fp_drain", m_axis.tdata, q[0]);
      void'(q.pop_front());
      step();
    end
    check("fp_empty", 64'(level), 64'd0);

    // 5b. Lone err_clr clears err and drop_cnt
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_err", 64'(err), 64'd0);
    check("clr_drop", 64'(drop_cnt), 64'd0);

    // 4. Framing: length 4 over 12 beats, then length 0 behaves as 1
    cfg_pkt_len = 16'd4;
    for (int i = 0; i < 12; i++) begin
      ddr_rd_valid = 1'b1; ddr_rd_data = beat(500 + i);
      step();
      check("frm4_tdata", m_axis.tdata, beat(500 + i));
      check("frm4_tlast", 64'(m_axis.tlast), 64'(((i + 1) % 4) == 0));
    end
    ddr_rd_valid = 1'b0;
    step();
    cfg_pkt_len = 16'd0;
    for (int i = 0; i < 3; i++) begin
      ddr_rd_valid = 1'b1; ddr_rd_data = beat(600 + i);
      step();
      check("frm0_tlast", 64'(m_axis.tlast), 64'd1);
    end
    ddr_rd_valid = 1'b0;
    step();
    check("frm0_empty", 64'(level), 64'd0);

    // 5. Clear race: overflow with err_clr -> overflow wins with drop_cnt=1
    cfg_pkt_len = 16'd1;
    m_axis.tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ddr_rd_valid = 1'b1; ddr_rd_data = beat(700 + i);
      step();
    end
    step();  // first overflow, drop_cnt -> 1
    check("race_pre_drop", 64'(drop_cnt), 64'd1);
    err_clr = 1'b1;
    step();  // overflow again together with clear
    err_clr = 1'b0; ddr_rd_valid = 1'b0;
    check("race_err", 64'(err), 64'd1);
    check("race_drop", 64'(drop_cnt), 64'd1);
    check("race_head", m_axis.tdata, beat(700));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("race_clr_err", 64'(err), 64'd0);
    check("race_clr_drop", 64'(drop_cnt), 64'd0);

    // 6. Reset mid-packet flushes and restarts framing
    rst = 1'b1;
    step();
    rst = 1'b0;
    cfg_pkt_len = 16'd4;
    for (int i = 0; i < 3; i++) begin
      ddr_rd_valid = 1'b1; ddr_rd_data = beat(800 + i);
      step();
    end
    ddr_rd_valid = 1'b0;
    check("mid_level", 64'(level), 64'd3);
    m_axis.tready = 1'b1;
    step();  // one beat popped, packet now in progress
    m_axis.tready = 1'b0;
    check("mid_level_pop", 64'(level), 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("mid_rst_tlast", 64'(m_axis.tlast), 64'd0);
    m_axis.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ddr_rd_valid = 1'b1; ddr_rd_data = beat(900 + i);
      step();
      check("new_pkt_tdata", m_axis.tdata, beat(900 + i));
      check("new_pkt_tlast", 64'(m_axis.tlast), 64'(i == 3));
    end
    ddr_rd_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
